// File: rtl/muldiv_pkg.sv
// Shared encodings and default sizes for the iterative multiply/divide unit.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_ADDR_W = 3;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier and restoring divider sharing one 2*WIDTH working register.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
`ifdef MULDIV_DIV_EN
    input  logic             op,
`endif
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
`ifdef MULDIV_DIV_EN
    ,
    output logic             divisor_zero
`endif
);

    // Upper half: partial product / remainder. Lower half: multiplier / quotient.
    logic [2*WIDTH-1:0] prod_r;
    logic [2*WIDTH-1:0] prod_step_s;
    logic [2*WIDTH-1:0] res_full_s;
    logic [WIDTH-1:0]   opnd_r;
    logic [WIDTH:0]     add_s;
`ifdef MULDIV_DIV_EN
    logic               op_r;
    logic [WIDTH:0]     shift_s;
    logic [WIDTH:0]     diff_s;
`endif

    // One iteration of the selected algorithm applied to the working register.
    always_comb begin
        add_s       = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                      (prod_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        prod_step_s = {add_s, prod_r[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        shift_s = prod_r[2*WIDTH-1:WIDTH-1];
        diff_s  = shift_s - {1'b0, opnd_r};
        if (op_r == OP_DIV) begin
            if (diff_s[WIDTH] == 1'b0) begin
                prod_step_s = {diff_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b1};
            end else begin
                prod_step_s = {shift_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            prod_step_s = {add_s, prod_r[WIDTH-1:1]};
        end
`endif
    end

    // Working register: load fresh operands or advance by one iteration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_r <= {(2*WIDTH){1'b0}};
            opnd_r <= {WIDTH{1'b0}};
`ifdef MULDIV_DIV_EN
            op_r   <= OP_MUL;
`endif
        end else if (load) begin
`ifdef MULDIV_DIV_EN
            op_r <= op;
            if (op == OP_DIV) begin
                prod_r <= {{WIDTH{1'b0}}, operand_a};
                opnd_r <= operand_b;
            end else begin
                prod_r <= {{WIDTH{1'b0}}, operand_b};
                opnd_r <= operand_a;
            end
`else
            prod_r <= {{WIDTH{1'b0}}, operand_b};
            opnd_r <= operand_a;
`endif
        end else if (step) begin
            prod_r <= prod_step_s;
        end
    end

    // Result view including the step being taken this cycle, so the top can
    // capture it on the same edge that enters DONE.
    always_comb begin
        res_full_s = step ? prod_step_s : prod_r;
        res_lo     = res_full_s[WIDTH-1:0];
        res_hi     = res_full_s[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
        divisor_zero = (opnd_r == {WIDTH{1'b0}});
        if ((op_r == OP_DIV) && divisor_zero) begin
            res_lo = {WIDTH{1'b1}};
            res_hi = prod_r[WIDTH-1:0];
        end else begin
            res_lo = res_full_s[WIDTH-1:0];
            res_hi = res_full_s[2*WIDTH-1:WIDTH];
        end
`endif
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with a one-cycle register-file write at completion.
// Divide support (DIV state, div_by_zero) is enabled by defining MULDIV_DIV_EN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic [WIDTH-1:0]  operand_a,
    input  logic [WIDTH-1:0]  operand_b,
    input  logic [ADDR_W-1:0] dest,
    output logic              busy,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [WIDTH-1:0]  wb_data,
    output logic [WIDTH-1:0]  hi,
    output logic              div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [ADDR_W-1:0] dest_r;
    logic              load_s;
    logic              step_s;
    logic              finish_s;
    logic [WIDTH-1:0]  res_lo_s;
    logic [WIDTH-1:0]  res_hi_s;
    logic              busy_r;
    logic              wb_en_r;
    logic [ADDR_W-1:0] wb_dest_r;
    logic [WIDTH-1:0]  wb_data_r;
    logic [WIDTH-1:0]  hi_r;
`ifdef MULDIV_DIV_EN
    logic              divisor_zero_s;
    logic              div_by_zero_r;
`endif

    muldiv_datapath #(
        .WIDTH        (WIDTH)
    ) u_datapath (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load_s),
        .step         (step_s),
`ifdef MULDIV_DIV_EN
        .op           (op),
`endif
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .res_lo       (res_lo_s),
        .res_hi       (res_hi_s)
`ifdef MULDIV_DIV_EN
        ,
        .divisor_zero (divisor_zero_s)
`endif
    );

    // Next-state, iteration counter and datapath control.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && (op == OP_MUL)) begin
                    state_nxt_s = ST_MUL;
                    cnt_nxt_s   = CNT_W'(WIDTH);
                    load_s      = 1'b1;
                end
`ifdef MULDIV_DIV_EN
                else if (start && (op == OP_DIV)) begin
                    state_nxt_s = ST_DIV;
                    cnt_nxt_s   = CNT_W'(WIDTH);
                    load_s      = 1'b1;
                end
`endif
                else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                step_s    = 1'b1;
                cnt_nxt_s = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = ST_DONE;
                    finish_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
`ifdef MULDIV_DIV_EN
            ST_DIV: begin
                if (divisor_zero_s) begin
                    state_nxt_s = ST_DONE;
                    cnt_nxt_s   = CNT_W'(0);
                    finish_s    = 1'b1;
                end else begin
                    step_s    = 1'b1;
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_nxt_s = ST_DONE;
                        finish_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_DIV;
                    end
                end
            end
`endif
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and latched destination.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_W'(0);
            dest_r  <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (load_s) begin
                dest_r <= dest;
            end
        end
    end

    // Registered outputs; results are captured on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            wb_en_r   <= 1'b0;
            wb_dest_r <= {ADDR_W{1'b0}};
            wb_data_r <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
        end else begin
            busy_r  <= (state_nxt_s != ST_IDLE);
            wb_en_r <= finish_s && (dest_r != {ADDR_W{1'b0}});
            if (finish_s) begin
                wb_dest_r <= dest_r;
                wb_data_r <= res_lo_s;
                hi_r      <= res_hi_s;
            end
        end
    end

`ifdef MULDIV_DIV_EN
    // Divide-by-zero flag, valid only in the DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_by_zero_r <= 1'b0;
        end else begin
            div_by_zero_r <= finish_s && (state_r == ST_DIV) && divisor_zero_s;
        end
    end

    assign div_by_zero = div_by_zero_r;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy    = busy_r;
    assign wb_en   = wb_en_r;
    assign wb_dest = wb_dest_r;
    assign wb_data = wb_data_r;
    assign hi      = hi_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
// Divide scenarios run when MULDIV_DIV_EN is defined; otherwise divide requests must be ignored.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W  = 16;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          op;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic [AW-1:0] dest;
    logic          busy;
    logic          wb_en;
    logic [AW-1:0] wb_dest;
    logic [W-1:0]  wb_data;
    logic [W-1:0]  hi;
    logic          div_by_zero;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [W-1:0]  last_lo = 16'h0000;
    logic [W-1:0]  last_hi = 16'h0000;

    typedef struct packed {
        logic [AW-1:0] d;
        logic [W-1:0]  lo;
        logic [W-1:0]  hi;
    } wb_t;

    wb_t pulse_q[$];

    muldiv_unit #(
        .WIDTH       (W),
        .ADDR_W      (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .dest        (dest),
        .busy        (busy),
        .wb_en       (wb_en),
        .wb_dest     (wb_dest),
        .wb_data     (wb_data),
        .hi          (hi),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write-back pulse seen between clock edges.
    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            pulse_q.push_back({wb_dest, wb_data, hi});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands; lat is the cycle of DONE after acceptance.
    task automatic model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] lo, output logic [W-1:0] hv,
                         output logic dz, output int lat);
        logic [2*W-1:0] p;
        dz  = 1'b0;
        lat = W;
        if (o == OP_MUL) begin
            p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            lo = p[W-1:0];
            hv = p[2*W-1:W];
        end else if (b == 16'h0000) begin
            lo  = 16'hFFFF;
            hv  = a;
            dz  = 1'b1;
            lat = 1;
        end else begin
            lo = a / b;
            hv = a % b;
        end
    endtask

    // Issue one operation at a negedge and check its completion timing and results.
    task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] d, input string tag);
        logic [W-1:0] elo;
        logic [W-1:0] ehi;
        logic         edz;
        int           lat;
        model(o, a, b, elo, ehi, edz, lat);
        pulse_q.delete();
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        dest      = d;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        operand_a = 16'($urandom);
        operand_b = 16'($urandom);
        dest      = 3'($urandom);
        op        = 1'($urandom);
        for (int j = 0; j <= lat; j++) begin
            if (j == lat - 1) begin
                check_eq({tag, "_busy_pre"}, 32'(busy), 32'd1);
                check_eq({tag, "_wben_pre"}, 32'(wb_en), 32'd0);
            end
            if (j == lat) begin
                check_eq({tag, "_busy_done"}, 32'(busy), 32'd1);
                check_eq({tag, "_wben"}, 32'(wb_en), 32'(d != 3'd0));
                check_eq({tag, "_dest"}, 32'(wb_dest), 32'(d));
                check_eq({tag, "_lo"}, 32'(wb_data), 32'(elo));
                check_eq({tag, "_hi"}, 32'(hi), 32'(ehi));
                check_eq({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
            end
            @(negedge clk);
        end
        check_eq({tag, "_busy_post"}, 32'(busy), 32'd0);
        check_eq({tag, "_wben_post"}, 32'(wb_en), 32'd0);
        check_eq({tag, "_dbz_post"}, 32'(div_by_zero), 32'd0);
        check_eq({tag, "_hi_hold"}, 32'(hi), 32'(ehi));
        check_eq({tag, "_lo_hold"}, 32'(wb_data), 32'(elo));
        check_eq({tag, "_pulses"}, 32'(pulse_q.size()), 32'(d != 3'd0));
        last_lo = elo;
        last_hi = ehi;
    endtask

    // A divide request must be dropped when divide support is not built in.
    task automatic do_ignored(input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        op        = OP_DIV;
        operand_a = a;
        operand_b = b;
        dest      = 3'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check_eq("ign_busy", 32'(busy), 32'd0);
            check_eq("ign_wben", 32'(wb_en), 32'd0);
            check_eq("ign_dbz", 32'(div_by_zero), 32'd0);
            @(negedge clk);
        end
        check_eq("ign_hi", 32'(hi), 32'(last_hi));
        check_eq("ign_lo", 32'(wb_data), 32'(last_lo));
    endtask

    // Second start mid-operation and a start in DONE must both be ignored.
    task automatic start_while_busy();
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic [W-1:0] elo;
        logic [W-1:0] ehi;
        logic         edz;
        int           lat;
        a1 = 16'($urandom);
        b1 = 16'($urandom);
        model(OP_MUL, a1, b1, elo, ehi, edz, lat);
        pulse_q.delete();
        start     = 1'b1;
        op        = OP_MUL;
        operand_a = a1;
        operand_b = b1;
        dest      = 3'd2;
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 20; j++) begin
            start     = (j == 4) || (j == 16);
            operand_a = ~a1;
            operand_b = b1 + 16'd1;
            dest      = 3'd5;
            @(negedge clk);
        end
        check_eq("swb_busy", 32'(busy), 32'd0);
        check_eq("swb_pulses", 32'(pulse_q.size()), 32'd1);
        if (pulse_q.size() > 0) begin
            check_eq("swb_dest", 32'(pulse_q[0].d), 32'd2);
            check_eq("swb_lo", 32'(pulse_q[0].lo), 32'(elo));
            check_eq("swb_hi", 32'(pulse_q[0].hi), 32'(ehi));
        end
        last_lo = elo;
        last_hi = ehi;
    endtask

    // Reset eight edges into a multiply, with a start presented alongside it.
    task automatic reset_mid_op();
        pulse_q.delete();
        start     = 1'b1;
        op        = OP_MUL;
        operand_a = 16'hBEEF;
        operand_b = 16'h1234;
        dest      = 3'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_wben", 32'(wb_en), 32'd0);
        check_eq("rst_dest", 32'(wb_dest), 32'd0);
        check_eq("rst_lo", 32'(wb_data), 32'd0);
        check_eq("rst_hi", 32'(hi), 32'd0);
        check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("rst_busy_after", 32'(busy), 32'd0);
        check_eq("rst_pulses", 32'(pulse_q.size()), 32'd0);
        last_lo = 16'h0000;
        last_hi = 16'h0000;
    endtask

    initial begin
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic          ro;
        logic [AW-1:0] rd;
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = OP_MUL;
        operand_a = 16'h0000;
        operand_b = 16'h0000;
        dest      = 3'd0;
        repeat (3) @(negedge clk);
        check_eq("init_busy", 32'(busy), 32'd0);
        check_eq("init_wben", 32'(wb_en), 32'd0);
        check_eq("init_dest", 32'(wb_dest), 32'd0);
        check_eq("init_lo", 32'(wb_data), 32'd0);
        check_eq("init_hi", 32'(hi), 32'd0);
        check_eq("init_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(OP_MUL, 16'h1234, 16'h0100, 3'd3, "mul_fixed");
        check_eq("mul_fixed_lo_const", 32'(last_lo), 32'h3400);
        do_op(OP_MUL, 16'h0003, 16'h0004, 3'd0, "mul_dest0");
        do_op(OP_MUL, 16'hFFFF, 16'hFFFF, 3'd7, "mul_max");
`ifdef MULDIV_DIV_EN
        do_op(OP_DIV, 16'd100, 16'd7, 3'd5, "div_fixed");
        do_op(OP_DIV, 16'h0055, 16'h0000, 3'd1, "div_zero");
        do_op(OP_DIV, 16'h0005, 16'h0009, 3'd2, "div_small");
`else
        do_ignored(16'd100, 16'd7);
        do_ignored(16'h0055, 16'h0000);
`endif
        start_while_busy();
        reset_mid_op();

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            rd = 3'($urandom_range(0, 7));
`ifdef MULDIV_DIV_EN
            ro = 1'($urandom_range(0, 1));
            do_op(ro, ra, rb, rd, "rand");
`else
            ro = OP_MUL;
            do_op(ro, ra, rb, rd, "rand");
            if ((i % 6) == 0) begin
                do_ignored(ra, rb);
            end
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
